// File: rtl/hv_sync_pkg.sv
// Shared timing defaults, position type and window helper for the VGA raster generator.
// Default values describe 640x480@60Hz from a 25 MHz pixel clock.
package hv_sync_pkg;

  typedef logic [31:0] hv_pos_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;
  localparam int unsigned V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Half-open window test: lo <= pos < hi.
  function automatic logic in_range(hv_pos_t pos, hv_pos_t lo, hv_pos_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/hv_sync_axis.sv
// One raster axis: wrapping position counter plus registered sync and visible decode.
// Outputs are decoded from the next count so they line up with the count they accompany.
module hv_sync_axis
  import hv_sync_pkg::*;
#(
  parameter int unsigned VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned FRONT   = H_FRONT_DEF,
  parameter int unsigned SYNC    = H_SYNC_DEF,
  parameter int unsigned BACK    = H_BACK_DEF,
  parameter logic        POL     = 1'b0,
  localparam int unsigned TOTAL  = VISIBLE + FRONT + SYNC + BACK,
  localparam int unsigned CW     = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          visible
);

  localparam hv_pos_t       SYNC_LO = hv_pos_t'(VISIBLE + FRONT);
  localparam hv_pos_t       SYNC_HI = hv_pos_t'(VISIBLE + FRONT + SYNC);
  localparam hv_pos_t       VIS_END = hv_pos_t'(VISIBLE);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);

  logic          at_last;
  logic [CW-1:0] count_next;

  assign at_last = (count == LAST);
  assign wrap    = advance && at_last;

  always_comb begin
    // NOTE: default assignment first so no path leaves count_next unassigned (no latch).
    count_next = count;
    if (advance) begin
      count_next = at_last ? '0 : count + 1'b1;
    end
  end

  // Position 0 is visible and outside the sync window, so reset values match count = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      sync    <= ~POL;
      visible <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      count   <= count_next;
      sync    <= in_range(hv_pos_t'(count_next), SYNC_LO, SYNC_HI) ? POL : ~POL;
      visible <= (hv_pos_t'(count_next) < VIS_END);
    end
  end

endmodule

// File: rtl/hv_sync_gen.sv
// VGA raster timing generator: free-running X/Y counters, h/v sync and display-area flag.
// Define HV_SYNC_FRAME_PULSE_EN to add a one-cycle frame_start pulse at position (0,0).
module hv_sync_gen
  import hv_sync_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  output logic    vga_h_sync,
  output logic    vga_v_sync,
  output logic    inDisplayArea,
  output hv_pos_t CounterX,
  output hv_pos_t CounterY
`ifdef HV_SYNC_FRAME_PULSE_EN
  ,
  output logic    frame_start
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);

  logic [HCW-1:0] h_count;
  logic [VCW-1:0] v_count;
  logic           h_wrap;
  logic           v_wrap;
  logic           h_visible;
  logic           v_visible;

  hv_sync_axis #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (H_SYNC_POL)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (1'b1),
    .count   (h_count),
    .wrap    (h_wrap),
    .sync    (vga_h_sync),
    .visible (h_visible)
  );

  // Vertical axis steps only at end of line, which keeps vsync line-granular.
  hv_sync_axis #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (V_SYNC_POL)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .count   (v_count),
    .wrap    (v_wrap),
    .sync    (vga_v_sync),
    .visible (v_visible)
  );

  assign inDisplayArea = h_visible && v_visible;
  assign CounterX      = hv_pos_t'(h_count);
  assign CounterY      = hv_pos_t'(v_count);

`ifdef HV_SYNC_FRAME_PULSE_EN
  // v_wrap marks the edge into (0,0); reset leaves it low, so no pulse right after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
    end
  end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_hv_sync_gen.sv
// Directed bench for hv_sync_gen: default 640x480 timing plus a tiny 8/2/2/2 x 4/1/1/1 override.
// An independent position model predicts counters, sync windows and display area every cycle.
module tb_hv_sync_gen;
  import hv_sync_pkg::*;

  logic    clk;
  logic    rst_n;

  logic    h_sync, v_sync, de;
  hv_pos_t cx, cy;
  logic    s_h_sync, s_v_sync, s_de;
  hv_pos_t s_cx, s_cy;
`ifdef HV_SYNC_FRAME_PULSE_EN
  logic    fs, s_fs;
`endif

  hv_sync_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vga_h_sync    (h_sync),
    .vga_v_sync    (v_sync),
    .inDisplayArea (de),
    .CounterX      (cx),
    .CounterY      (cy)
`ifdef HV_SYNC_FRAME_PULSE_EN
    ,
    .frame_start   (fs)
`endif
  );

  hv_sync_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
  ) dut_s (
    .clk           (clk),
    .rst_n         (rst_n),
    .vga_h_sync    (s_h_sync),
    .vga_v_sync    (s_v_sync),
    .inDisplayArea (s_de),
    .CounterX      (s_cx),
    .CounterY      (s_cy)
`ifdef HV_SYNC_FRAME_PULSE_EN
    ,
    .frame_start   (s_fs)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference positions for the default and small instances.
  int ex = 0, ey = 0, sx = 0, sy = 0;
  bit armed = 0;

  bit count_en = 0;
  int hs_low_line0 = 0;
  int de_line0     = 0;
  int s_vs_low     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t (model x=%0d y=%0d sx=%0d sy=%0d)",
               tag, got, exp, $time, ex, ey, sx, sy);
    end
  endtask

  task automatic check_all();
    check("x",    cx, ex);
    check("y",    cy, ey);
    check("hs",   {31'd0, h_sync}, 32'(!(ex >= 656 && ex < 752)));
    check("vs",   {31'd0, v_sync}, 32'(!(ey >= 490 && ey < 492)));
    check("de",   {31'd0, de},     32'(ex < 640 && ey < 480));
    check("s_x",  s_cx, sx);
    check("s_y",  s_cy, sy);
    check("s_hs", {31'd0, s_h_sync}, 32'(!(sx >= 10 && sx < 12)));
    check("s_vs", {31'd0, s_v_sync}, 32'(sy != 5));
    check("s_de", {31'd0, s_de},     32'(sx < 8 && sy < 4));
`ifdef HV_SYNC_FRAME_PULSE_EN
    check("fs",   {31'd0, fs},   32'(armed && ex == 0 && ey == 0));
    check("s_fs", {31'd0, s_fs}, 32'(armed && sx == 0 && sy == 0));
`endif
    if (count_en) begin
      if (ey == 0 && !h_sync) hs_low_line0++;
      if (ey == 0 && de)      de_line0++;
      if (!s_v_sync)          s_vs_low++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (ex == 799) begin
        ex = 0;
        ey = (ey == 524) ? 0 : ey + 1;
      end else begin
        ex++;
      end
      if (sx == 13) begin
        sx = 0;
        sy = (sy == 6) ? 0 : sy + 1;
      end else begin
        sx++;
      end
      armed = 1;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, then the first two lines of the default mode and ~17 small frames.
    count_en = 1;
    check_all();
    rst_n = 1'b1;
    tick();
    check("x_first_after_release", cx, 32'd1);
    repeat (1699) tick();
    count_en = 0;

    check("hs_low_cycles_line0", hs_low_line0, 32'd96);
    check("de_cycles_line0",     de_line0,     32'd640);
    check("s_vs_low_cycles",     s_vs_low,     32'd238);

    // Walk to X=300 on the current line, then reset asynchronously mid-line.
    guard = 0;
    while (ex != 300 && guard < 1000) begin
      tick();
      guard++;
    end
    check("reach_x300", cx, 32'd300);

    #5 rst_n = 1'b0;
    #1;
    ex = 0; ey = 0; sx = 0; sy = 0; armed = 0;
    check_all();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    tick();
    check("x_after_midframe_reset", cx, 32'd1);
    check("y_after_midframe_reset", cy, 32'd0);
    repeat (300) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
